// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchroniser, debounce and
// key-code encoding with a registered kbEN strobe per accepted press.
//
// state      | meaning
// S_SCAN     | step through rows, sample columns on last dwell clock
// S_DEBOUNCE | row held, candidate column must stay low DEBOUNCE clocks
// S_PULSE    | pressedkey loaded, kbEN asserted for KBEN_CYCLES clocks
// S_RELEASE  | row held, wait for all columns high DEBOUNCE clocks
module keypad_scanner #(
    parameter int SCAN_DIV    = 1200,
    parameter int DEBOUNCE    = 60000,
    parameter int KBEN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] pressedkey,
    output logic       kbEN
);

    localparam int MAX_A = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int MAX_P = (MAX_A > KBEN_CYCLES) ? MAX_A : KBEN_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] SCAN_TC  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TC   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] PULSE_TC = CW'(KBEN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PULSE,
        S_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    row, row_nx;
    logic [1:0]    col, col_nx;
    logic [3:0]    key_nx;
    logic [3:0]    sync1, scols;
    logic [3:0]    cand_pat;
    logic          single_low;
    logic [1:0]    low_col;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd12;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd13;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd14;
            4'hC: code = 4'd11;
            4'hD: code = 4'd0;
            4'hE: code = 4'd10;
            default: code = 4'd15;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b1111;
            scols <= 4'b1111;
        end else begin
            sync1 <= cols;
            scols <= sync1;
        end
    end

    // Only a pattern with exactly one low column is a valid candidate.
    always_comb begin
        single_low = 1'b1;
        low_col    = 2'd0;
        case (scols)
            4'b1110: low_col = 2'd0;
            4'b1101: low_col = 2'd1;
            4'b1011: low_col = 2'd2;
            4'b0111: low_col = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    assign cand_pat = ~(4'b0001 << col);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        row_nx   = row;
        col_nx   = col;
        key_nx   = pressedkey;
        case (state)
            S_SCAN: begin
                if (cnt == SCAN_TC) begin
                    cnt_nx = '0;
                    if (single_low) begin
                        col_nx   = low_col;
                        state_nx = S_DEBOUNCE;
                    end else begin
                        row_nx = row + 2'd1;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (scols != cand_pat) begin
                    state_nx = S_SCAN;
                    row_nx   = row + 2'd1;
                    cnt_nx   = '0;
                end else if (cnt == DEB_TC) begin
                    key_nx   = key_code(row, col);
                    state_nx = S_PULSE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt == PULSE_TC) begin
                    state_nx = S_RELEASE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (scols != 4'b1111) begin
                    cnt_nx = '0;
                end else if (cnt == DEB_TC) begin
                    state_nx = S_SCAN;
                    row_nx   = row + 2'd1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = S_SCAN;
                cnt_nx   = '0;
            end
        endcase
    end

    // kbEN lags the PULSE state by one clock so pressedkey leads it by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_SCAN;
            cnt        <= '0;
            row        <= 2'd0;
            col        <= 2'd0;
            rows       <= 4'b1110;
            pressedkey <= 4'd0;
            kbEN       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            row        <= row_nx;
            col        <= col_nx;
            rows       <= ~(4'b0001 << row_nx);
            pressedkey <= key_nx;
            kbEN       <= (state == S_PULSE);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner; a keypad matrix model
// drives cols from rows, and a monitor checks every kbEN pulse against a queue.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int KC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] pressedkey;
    logic       kbEN;
    logic [15:0] keys;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int cyc = 0;
    bit check_lat = 1'b0;
    bit rst_hit = 1'b0;
    int code_map[16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 11, 0, 10, 15};

    logic       kb_prev = 1'b0;
    logic [3:0] pk_prev = 4'd0;
    logic [3:0] rows_prev = 4'b1111;
    int         width = 0;
    int         last_r1 = 0;
    logic [3:0] neg_prev;
    logic [3:0] er;
    bit         seen;

    keypad_scanner #(
        .SCAN_DIV   (SD),
        .DEBOUNCE   (DB),
        .KBEN_CYCLES(KC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .pressedkey(pressedkey),
        .kbEN      (kbEN)
    );

    always #5 clk = ~clk;

    // Ideal matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hold(input int k, input int dur);
        keys[k] = 1'b1;
        idle(dur);
        keys = 16'h0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rows == 4'b1101 && rows_prev != 4'b1101) last_r1 = cyc;
            if (kbEN && !kb_prev) begin
                width = 1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got code %0d expected no pulse (t=%0t)", pressedkey, $time);
                end else begin
                    chk("pulse_code", pressedkey, exp_q.pop_front());
                end
                chk("code_setup", pk_prev, pressedkey);
                if (check_lat) chk("pulse_latency", cyc - last_r1, SD + DB + 1);
            end else if (kbEN) begin
                width++;
                chk("code_hold", pressedkey, pk_prev);
            end else if (kb_prev) begin
                if (!rst_hit) chk("pulse_width", width, KC);
                rst_hit = 1'b0;
            end
            kb_prev   = kbEN;
            pk_prev   = pressedkey;
            rows_prev = rows;
        end
    end

    initial begin
        keys  = 16'h0;
        reset = 1'b0;
        idle(3);
        chk("reset_rows", rows, 4'b1110);
        chk("reset_key", pressedkey, 0);
        chk("reset_kben", kbEN, 0);

        // idle scan: row index after k edges is (k/4) mod 4
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            er = ~(4'b0001 << ((k / SD) % 4));
            chk("scan_rows", rows, er);
        end
        idle(84);
        chk("idle_kben", kbEN, 0);
        chk("idle_key", pressedkey, 0);

        check_lat = 1'b1;
        exp_q.push_back(code_map[5]);
        press_hold(5, 60);
        idle(30);
        check_lat = 1'b0;
        chk("t2_drained", exp_q.size(), 0);

        exp_q.push_back(code_map[14]);
        for (int b = 0; b < 4; b++) begin
            keys[14] = 1'b1;
            idle(3);
            keys[14] = 1'b0;
            idle(3);
        end
        press_hold(14, 40);
        idle(30);
        chk("t3_drained", exp_q.size(), 0);

        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(code_map[i]);
            press_hold(i, 40);
            idle(30);
        end
        chk("t4_drained", exp_q.size(), 0);

        keys = 16'h0003;
        idle(60);
        keys = 16'h0;
        idle(30);

        // press rows 2 and 0 together right as row 2 becomes selected
        seen = 1'b0;
        neg_prev = rows;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (rows == 4'b1011 && neg_prev != 4'b1011) seen = 1'b1;
            neg_prev = rows;
        end
        chk("t5_row2_seen", seen, 1);
        exp_q.push_back(code_map[8]);
        keys = 16'h0108;
        idle(60);
        keys = 16'h0;
        idle(30);
        chk("t5_drained", exp_q.size(), 0);

        exp_q.push_back(code_map[6]);
        keys[6] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (kbEN) seen = 1'b1;
        end
        chk("t6_pulse_seen", seen, 1);
        #2;
        rst_hit = 1'b1;
        reset = 1'b0;
        #1;
        chk("t6_rst_kben", kbEN, 0);
        chk("t6_rst_rows", rows, 4'b1110);
        chk("t6_rst_key", pressedkey, 0);
        idle(3);
        exp_q.push_back(code_map[6]);
        reset = 1'b1;
        idle(60);
        keys = 16'h0;
        idle(30);
        chk("t6_drained", exp_q.size(), 0);

        // random presses: taps too short to debounce, holds long enough to be reported
        for (int n = 0; n < 24; n++) begin
            int k;
            int dur;
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) begin
                dur = $urandom_range(1, 6);
            end else begin
                dur = $urandom_range(40, 60);
                exp_q.push_back(code_map[k]);
            end
            press_hold(k, dur);
            idle(30);
        end
        idle(20);
        chk("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
